// File: rtl/sqrt_job_scheduler.sv
// rtl/sqrt_job_scheduler.sv - 4-deep sample FIFO feeding one-at-a-time jobs to a complex-sqrt controller
// Optional: define SQRT_ZERO_BYPASS_EN to answer (0,0) samples locally without issuing a job.
module sqrt_job_scheduler (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [15:0] s_x,
    input  logic signed [15:0] s_y,
    output logic signed [15:0] x_in,
    output logic signed [15:0] y_in,
    output logic               start,
    input  logic               cmplx_sqrt_valid,
    input  logic signed [15:0] cmplx_sqrt_real,
    input  logic signed [15:0] cmplx_sqrt_imag,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] m_real,
    output logic signed [15:0] m_imag,
    output logic               busy,
    output logic [2:0]         fifo_count
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
`ifdef SQRT_ZERO_BYPASS_EN
    localparam logic [1:0] ZERO   = 2'd3;
`endif

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [15:0] head_x;
    logic [15:0] head_y;
    logic        push;
    logic        pop;
    logic        capture;
    logic        can_issue;

    assign head_x    = mem[rd_ptr][31:16];
    assign head_y    = mem[rd_ptr][15:0];
    assign s_ready   = (fifo_count != 3'd4);
    assign push      = s_valid && s_ready;
    assign capture   = (state == WAIT) && cmplx_sqrt_valid;
`ifdef SQRT_ZERO_BYPASS_EN
    assign pop       = capture || (state == ZERO);
`else
    assign pop       = capture;
`endif
    // A new job may start only if the output slot is free or is draining this edge.
    assign can_issue = (fifo_count != 3'd0) && (!m_valid || m_ready);
    assign start     = (state == LAUNCH);
    assign busy      = (state == LAUNCH) || (state == WAIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (can_issue) begin
`ifdef SQRT_ZERO_BYPASS_EN
                    state_next = ((head_x == 16'h0000) && (head_y == 16'h0000)) ? ZERO : LAUNCH;
`else
                    state_next = LAUNCH;
`endif
                end
            end
            LAUNCH:  state_next = WAIT;
            WAIT:    if (cmplx_sqrt_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_x, s_y};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            x_in       <= 16'sh0000;
            y_in       <= 16'sh0000;
            m_valid    <= 1'b0;
            m_real     <= 16'sh0000;
            m_imag     <= 16'sh0000;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)      fifo_count <= fifo_count + 3'd1;
            else if (pop && !push) fifo_count <= fifo_count - 3'd1;
            // Operands are frozen here so the controller sees them stable for the whole job.
            if ((state == IDLE) && (state_next == LAUNCH)) begin
                x_in <= head_x;
                y_in <= head_y;
            end
            if (capture) begin
                m_valid <= 1'b1;
                m_real  <= cmplx_sqrt_real;
                m_imag  <= cmplx_sqrt_imag;
            end
`ifdef SQRT_ZERO_BYPASS_EN
            else if (state == ZERO) begin
                m_valid <= 1'b1;
                m_real  <= 16'sh0000;
                m_imag  <= 16'sh0000;
            end
`endif
            else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// tb/tb_sqrt_job_scheduler.sv - randomized self-checking bench for sqrt_job_scheduler
// Honours SQRT_ZERO_BYPASS_EN the same way the design does.
module tb_sqrt_job_scheduler;
    logic               clk;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_x = 16'sh0;
    logic signed [15:0] s_y = 16'sh0;
    logic signed [15:0] x_in, y_in, m_real, m_imag;
    logic signed [15:0] cmplx_sqrt_real, cmplx_sqrt_imag;
    logic               start, cmplx_sqrt_valid, m_valid, busy;
    logic               m_ready = 1'b0;
    logic [2:0]         fifo_count;

    logic        ctrl_valid = 1'b0;
    logic [15:0] ctrl_real = 16'h0, ctrl_imag = 16'h0;
    logic        stray_valid = 1'b0;
    logic [15:0] stray_real = 16'h0, stray_imag = 16'h0;
    int          ctrl_delay = 4;
    int          ctrl_cnt = 0;
    int          ready_mode = 1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] start_q[$];
    int          start_cyc[$];
    int          valid_cyc[$];

    assign cmplx_sqrt_valid = ctrl_valid | stray_valid;
    assign cmplx_sqrt_real  = stray_valid ? stray_real : ctrl_real;
    assign cmplx_sqrt_imag  = stray_valid ? stray_imag : ctrl_imag;

    sqrt_job_scheduler dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .x_in(x_in), .y_in(y_in), .start(start),
        .cmplx_sqrt_valid(cmplx_sqrt_valid), .cmplx_sqrt_real(cmplx_sqrt_real),
        .cmplx_sqrt_imag(cmplx_sqrt_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .busy(busy), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ctrl_fn(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'h2000 && y == 16'h0000) return {16'h2D41, 16'h0000};
        return {x ^ 16'hA5A5, y + 16'd3};
    endfunction

    function automatic logic is_zero(input logic [31:0] s);
        return s == 32'h0;
    endfunction

    function automatic logic [31:0] expect_fn(input logic [31:0] s);
`ifdef SQRT_ZERO_BYPASS_EN
        if (is_zero(s)) return 32'h0;
`endif
        return ctrl_fn(s[31:16], s[15:0]);
    endfunction

    function automatic logic [15:0] rnz();
        return 16'($urandom_range(1, 65535));
    endfunction

    // Controller model, output consumer and event logger in one process so cycle stamps are coherent.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            ctrl_valid = 1'b0;
            if (!rst) ctrl_cnt = 0;
            else if (ctrl_cnt > 0) begin
                ctrl_cnt--;
                if (ctrl_cnt == 0) begin
                    ctrl_valid = 1'b1;
                    {ctrl_real, ctrl_imag} = ctrl_fn(x_in, y_in);
                    valid_cyc.push_back(cyc);
                end
            end
            if (rst && start) begin
                start_q.push_back({x_in, y_in});
                start_cyc.push_back(cyc);
                ctrl_cnt = (ctrl_delay > 0) ? ctrl_delay : int'($urandom_range(1, 8));
            end
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && m_ready) got_q.push_back({m_real, m_imag});
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); start_q.delete();
        start_cyc.delete(); valid_cyc.delete();
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y);
        int n = 0;
        s_valid = 1'b1; s_x = x; s_y = y;
        while (!s_ready && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL push_timeout: s_ready=%0b after %0d cycles want 1", s_ready, n);
        end else exp_q.push_back({x, y});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_results(input int want);
        int n = 0;
        while (got_q.size() < want && n < 3000) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({start, busy, m_valid, s_ready, fifo_count} !== 7'b0001_000) begin
            failures++;
            $display("FAIL reset_ctrl: got start/busy/m_valid/s_ready/count=%b want 0001000",
                     {start, busy, m_valid, s_ready, fifo_count});
        end
        checks++;
        if ({x_in, y_in, m_real, m_imag} !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", {x_in, y_in, m_real, m_imag});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || fifo_count !== 3'd0 || start !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got s_ready=%0b count=%0d start=%0b want 1 0 0",
                     s_ready, fifo_count, start);
        end
    endtask

    task automatic test_single();
        int  n;
        logic held = 1'b1;
        clear_logs(); ctrl_delay = 20; ready_mode = 1;
        push(16'h2000, 16'h0000);
        checks++;
        if (fifo_count !== 3'd1 || start !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: got count=%0d start=%0b want 1 0", fifo_count, start);
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || busy !== 1'b1 || x_in !== 16'sh2000 || y_in !== 16'sh0000) begin
            failures++;
            $display("FAIL single_start: got start=%0b busy=%0b x_in=%h y_in=%h want 1 1 2000 0000",
                     start, busy, x_in, y_in);
        end
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!m_valid && (start !== 1'b0 || x_in !== 16'sh2000 || busy !== 1'b1)) held = 1'b0;
        end while (!m_valid && n < 200);
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL single_hold: got held=%0b want 1 (x_in stable, one start)", held);
        end
        checks++;
        if (n != 21) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles start->m_valid want 21", n);
        end
        checks++;
        if (m_valid !== 1'b1 || m_real !== 16'sh2D41 || m_imag !== 16'sh0000) begin
            failures++;
            $display("FAIL single_result: got v=%0b %h/%h want 1 2d41/0000", m_valid, m_real, m_imag);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_count !== 3'd0 || start_q.size() != 1 || got_q.size() != 1) begin
            failures++;
            $display("FAIL single_done: got v=%0b count=%0d starts=%0d results=%0d want 0 0 1 1",
                     m_valid, fifo_count, start_q.size(), got_q.size());
        end
    endtask

    task automatic test_fill();
        logic [15:0] x5 = rnz(), y5 = rnz();
        clear_logs(); ctrl_delay = 40; ready_mode = 1;
        for (int i = 0; i < 4; i++) push(rnz(), rnz());
        checks++;
        if (fifo_count !== 3'd4 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got count=%0d s_ready=%0b want 4 0", fifo_count, s_ready);
        end
        s_valid = 1'b1; s_x = x5; s_y = y5;
        repeat (10) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_hold: got count=%0d s_ready=%0b want 4 0", fifo_count, s_ready);
        end
        push(x5, y5);
        push(rnz(), rnz());
        wait_results(6);
        checks++;
        if (got_q.size() != 6 || start_q.size() != 6) begin
            failures++;
            $display("FAIL fill_count: got results=%0d starts=%0d want 6 6", got_q.size(), start_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== expect_fn(exp_q[i]) || start_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fill_order[%0d]: got res=%h issued=%h want res=%h issued=%h",
                         i, got_q[i], start_q[i], expect_fn(exp_q[i]), exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        logic        ok = 1'b1;
        logic [15:0] hold_r;
        int          ns;
        clear_logs(); ctrl_delay = int'($urandom_range(3, 10)); ready_mode = 0;
        push(rnz(), rnz());
        push(rnz(), rnz());
        while (!m_valid && n < 200) begin @(negedge clk); n++; end
        hold_r = m_real;
        ns = start_q.size();
        repeat (50) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_real !== hold_r || start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || n >= 200) begin
            failures++;
            $display("FAIL bp_hold: got stable=%0b wait=%0d want stable=1 within 200", ok, n);
        end
        checks++;
        if (start_q.size() != 1 || ns != 1) begin
            failures++;
            $display("FAIL bp_no_start: got starts=%0d want 1", start_q.size());
        end
        ready_mode = 1;
        wait_results(2);
        checks++;
        if (got_q.size() != 2) begin
            failures++;
            $display("FAIL bp_count: got %0d results want 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== expect_fn(exp_q[i])) begin
                failures++;
                $display("FAIL bp_result[%0d]: got %h want %h", i, got_q[i], expect_fn(exp_q[i]));
            end
        end
    endtask

    task automatic test_spacing();
        logic ok = 1'b1;
        clear_logs(); ctrl_delay = 5; ready_mode = 1;
        push(rnz(), rnz());
        push(rnz(), rnz());
        wait_results(2);
        checks++;
        if (start_cyc.size() != 2 || valid_cyc.size() != 2) begin
            failures++;
            $display("FAIL spacing_count: got starts=%0d valids=%0d want 2 2", start_cyc.size(), valid_cyc.size());
        end else begin
            checks++;
            if (start_cyc[1] - valid_cyc[0] != 2) begin
                failures++;
                $display("FAIL spacing_gap: got %0d cycles valid->start want 2", start_cyc[1] - valid_cyc[0]);
            end
        end
        repeat (3) @(negedge clk);
        stray_real = 16'h7777; stray_imag = 16'h1234; stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || start !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok || got_q.size() != 2 || start_q.size() != 2) begin
            failures++;
            $display("FAIL spacing_stray: got quiet=%0b results=%0d starts=%0d want 1 2 2",
                     ok, got_q.size(), start_q.size());
        end
    endtask

    task automatic test_zero();
        clear_logs(); ctrl_delay = 4; ready_mode = 1;
        push(16'h0000, 16'h0000);
`ifdef SQRT_ZERO_BYPASS_EN
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_state: got start=%0b busy=%0b v=%0b want 0 0 0", start, busy, m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_real !== 16'sh0 || m_imag !== 16'sh0) begin
            failures++;
            $display("FAIL zero_result: got v=%0b %h/%h want 1 0000/0000", m_valid, m_real, m_imag);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (start_q.size() != 0 || got_q.size() != 1 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL zero_done: got starts=%0d results=%0d count=%0d want 0 1 0",
                     start_q.size(), got_q.size(), fifo_count);
        end
`else
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || x_in !== 16'sh0 || y_in !== 16'sh0) begin
            failures++;
            $display("FAIL zero_issue: got start=%0b x_in=%h y_in=%h want 1 0000 0000", start, x_in, y_in);
        end
        wait_results(1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'hA5A5_0003) begin
            failures++;
            $display("FAIL zero_result: got n=%0d first=%h want 1 a5a50003", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 32'hx);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] issue_q[$];
        logic        ok = 1'b1;
        logic [15:0] x, y;
        clear_logs(); ctrl_delay = 0; ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) begin x = 16'h0; y = 16'h0; end
            else begin x = 16'($urandom); y = 16'($urandom); end
            push(x, y);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_results(24);
        ready_mode = 1;
        foreach (exp_q[i]) begin
`ifdef SQRT_ZERO_BYPASS_EN
            if (!is_zero(exp_q[i])) issue_q.push_back(exp_q[i]);
`else
            issue_q.push_back(exp_q[i]);
`endif
        end
        checks++;
        if (got_q.size() != exp_q.size() || start_q.size() != issue_q.size()) begin
            failures++;
            $display("FAIL random_count: got results=%0d starts=%0d want %0d %0d",
                     got_q.size(), start_q.size(), exp_q.size(), issue_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== expect_fn(exp_q[i])) begin
                failures++;
                $display("FAIL random_result[%0d]: got %h want %h", i, got_q[i], expect_fn(exp_q[i]));
            end
        end
        for (int i = 0; i < start_q.size() && i < issue_q.size(); i++) begin
            if (start_q[i] !== issue_q[i]) ok = 1'b0;
            if (i > 0 && i <= valid_cyc.size() && start_cyc[i] - valid_cyc[i-1] < 2) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL random_issue: got ordered_and_spaced=%0b want 1", ok);
        end
    endtask

    task automatic test_reset_mid();
        logic quiet = 1'b1;
        clear_logs(); ctrl_delay = 30; ready_mode = 1;
        for (int i = 0; i < 3; i++) push(rnz(), rnz());
        checks++;
        if (busy !== 1'b1 || start !== 1'b0 || fifo_count !== 3'd3) begin
            failures++;
            $display("FAIL rmid_wait: got busy=%0b start=%0b count=%0d want 1 0 3", busy, start, fifo_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({start, busy, m_valid, s_ready, fifo_count} !== 7'b0001_000 ||
            {x_in, y_in, m_real, m_imag} !== 64'h0) begin
            failures++;
            $display("FAIL rmid_async: got ctrl=%b data=%h want 0001000 0",
                     {start, busy, m_valid, s_ready, fifo_count}, {x_in, y_in, m_real, m_imag});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || start !== 1'b0 || fifo_count !== 3'd0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || got_q.size() != 0 || start_q.size() != 1) begin
            failures++;
            $display("FAIL rmid_after: got quiet=%0b results=%0d starts=%0d want 1 0 1",
                     quiet, got_q.size(), start_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_spacing();
        test_zero();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
